// File: rtl/mem_port_master.sv
// Word-wide RAM initiator: one load/store at a time, lane extraction with sign/zero extension,
// sub-word stores as read-modify-write. Optional MISALIGN_FAULT_EN faults misaligned/reserved requests.
module mem_port_master #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [1:0]        ram_size,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, MERGE, WR, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   lat_cnt;
  logic [1:0]         lane_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic               write_q;
  logic [31:0]        wdata_q;
  logic [31:0]        data_q;
  logic               is_fault;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_data;
  logic [31:0]        merged;

`ifdef MISALIGN_FAULT_EN
  always_comb begin
    is_fault = 1'b0;
    case (req_size)
      2'b01:   is_fault = req_addr[0];
      2'b10:   is_fault = |req_addr[1:0];
      2'b11:   is_fault = 1'b1;
      default: is_fault = 1'b0;
    endcase
  end
`else
  assign is_fault = 1'b0;
`endif

  always_comb begin
    lane_b = ram_rdata[{lane_q, 3'b000} +: 8];
    lane_h = ram_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_data = ram_rdata;
    endcase
  end

  always_comb begin
    merged = data_q;
    case (size_q)
      2'b00:   merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Reserved size is normalised to word at acceptance so later stages only see 00/01/10.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_size   <= 2'b10;
      lat_cnt    <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
    end else begin
      ram_size <= 2'b10;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lane_q    <= req_addr[1:0];
            size_q    <= (req_size == 2'b11) ? 2'b10 : req_size;
            signed_q  <= req_signed;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            ram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (is_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_write && req_size[1]) begin
              ram_wen   <= 1'b1;
              ram_wdata <= req_wdata;
              state     <= WR;
            end else begin
              ram_ren <= 1'b1;
              state   <= RD;
            end
          end
        end
        RD: begin
          ram_ren <= 1'b0;
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == CNT_W'(RD_LAT - 1)) begin
            if (write_q) begin
              data_q <= ram_rdata;
              state  <= MERGE;
            end else begin
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
              resp_fault <= 1'b0;
              state      <= RESP;
            end
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        MERGE: begin
          ram_wdata <= merged;
          ram_wen   <= 1'b1;
          state     <= WR;
        end
        WR: begin
          ram_wen    <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
